// File: rtl/oagu_stream_v2.sv
// Output address generator: buffers PE result beats in a small FIFO and writes
// them to the IOB along a run/jump address walk over an X/layer/Y loop nest.
module oagu_stream_v2 #(
   parameter int DW     = 256,
   parameter int AW     = 12,
   parameter int CW     = 8,
   parameter int FDEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic [AW-1:0] i_cfg_base,
   input  logic [CW-1:0] i_cfg_x_len,
   input  logic [CW-1:0] i_cfg_layers,
   input  logic [CW-1:0] i_cfg_y_len,
   input  logic [CW-1:0] i_cfg_run_len,
   input  logic [AW-1:0] i_cfg_jump,
   input  logic [DW-1:0] i_dat,
   input  logic          i_dat_vld,
   output logic          o_dat_rdy,
   output logic          o_wr_en,
   input  logic          i_wr_rdy,
   output logic [AW-1:0] o_waddr,
   output logic [DW-1:0] o_wdat,
   output logic          o_busy,
   output logic          o_done,
   output logic [1:0]    dbg_state
);

   localparam int PW = $clog2(FDEPTH);
   localparam int TW = 3 * CW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0] x_len, layers, y_len, run_len;
   logic [AW-1:0] jump;
   logic [TW-1:0] total, acc_cnt;
   logic [CW-1:0] run_cnt, x_cnt, l_cnt, y_cnt;

   logic [DW-1:0] mem [FDEPTH];
   logic [PW:0]   wr_ptr, rd_ptr;

   logic empty, full, push, wr_hs, zero_cfg, start_ok;
   logic x_last, l_last, y_last, run_last, job_last;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

   assign o_busy    = (state != IDLE);
   assign o_done    = (state == FIN);
   assign o_dat_rdy = (state == RUN) && !full && (acc_cnt < total);
   assign o_wr_en   = (state == RUN) && !empty;
   assign o_wdat    = mem[rd_ptr[PW-1:0]];
   assign dbg_state = state;

   assign push     = i_dat_vld && o_dat_rdy;
   assign wr_hs    = o_wr_en && i_wr_rdy;
   assign zero_cfg = (i_cfg_x_len == '0) || (i_cfg_layers == '0) || (i_cfg_y_len == '0);
   assign start_ok = (state == IDLE) && i_start && !i_abort;

   assign x_last   = (x_cnt == x_len - CW'(1));
   assign l_last   = (l_cnt == layers - CW'(1));
   assign y_last   = (y_cnt == y_len - CW'(1));
   assign run_last = (run_len != '0) && (run_cnt + CW'(1) == run_len);
   assign job_last = wr_hs && x_last && l_last && y_last;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (i_abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (i_start) state_nxt = zero_cfg ? FIN : RUN;
            RUN:     if (job_last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_len   <= '0;
         layers  <= '0;
         y_len   <= '0;
         run_len <= '0;
         jump    <= '0;
         total   <= '0;
         acc_cnt <= '0;
         run_cnt <= '0;
         x_cnt   <= '0;
         l_cnt   <= '0;
         y_cnt   <= '0;
         o_waddr <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         for (int i = 0; i < FDEPTH; i++) mem[i] <= '0;
      end else if (i_abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (start_ok) begin
         x_len   <= i_cfg_x_len;
         layers  <= i_cfg_layers;
         y_len   <= i_cfg_y_len;
         run_len <= i_cfg_run_len;
         jump    <= i_cfg_jump;
         total   <= TW'(i_cfg_x_len) * TW'(i_cfg_layers) * TW'(i_cfg_y_len);
         acc_cnt <= '0;
         run_cnt <= '0;
         x_cnt   <= '0;
         l_cnt   <= '0;
         y_cnt   <= '0;
         o_waddr <= i_cfg_base;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[PW-1:0]] <= i_dat;
            wr_ptr  <= wr_ptr + (PW+1)'(1);
            acc_cnt <= acc_cnt + TW'(1);
         end
         if (wr_hs) begin
            rd_ptr <= rd_ptr + (PW+1)'(1);
            // The jump replaces the +1 step on the last beat of a run.
            if (run_last) begin
               o_waddr <= o_waddr + jump;
               run_cnt <= '0;
            end else begin
               o_waddr <= o_waddr + AW'(1);
               run_cnt <= run_cnt + CW'(1);
            end
            if (x_last) begin
               x_cnt <= '0;
               if (l_last) begin
                  l_cnt <= '0;
                  y_cnt <= y_last ? '0 : y_cnt + CW'(1);
               end else begin
                  l_cnt <= l_cnt + CW'(1);
               end
            end else begin
               x_cnt <= x_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_oagu_stream_v2.sv
// Directed bench for oagu_stream_v2: stimulus pushes expected {addr,data} on
// every accepted beat, an independent monitor pops and compares on each write.
module tb_oagu_stream_v2;
   localparam int DW = 256, AW = 12, CW = 8, FDEPTH = 4;
   localparam int CKW = 1 + AW + DW;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_start = 1'b0, i_abort = 1'b0;
   logic [AW-1:0] i_cfg_base = '0, i_cfg_jump = '0;
   logic [CW-1:0] i_cfg_x_len = '0, i_cfg_layers = '0, i_cfg_y_len = '0, i_cfg_run_len = '0;
   logic [DW-1:0] i_dat = '0;
   logic          i_dat_vld = 1'b0;
   logic          o_dat_rdy, o_wr_en, o_busy, o_done;
   logic          i_wr_rdy = 1'b1;
   logic [AW-1:0] o_waddr;
   logic [DW-1:0] o_wdat;
   logic [1:0]    dbg_state;

   oagu_stream_v2 #(.DW(DW), .AW(AW), .CW(CW), .FDEPTH(FDEPTH)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_cfg_base(i_cfg_base), .i_cfg_x_len(i_cfg_x_len), .i_cfg_layers(i_cfg_layers),
      .i_cfg_y_len(i_cfg_y_len), .i_cfg_run_len(i_cfg_run_len), .i_cfg_jump(i_cfg_jump),
      .i_dat(i_dat), .i_dat_vld(i_dat_vld), .o_dat_rdy(o_dat_rdy), .o_wr_en(o_wr_en),
      .i_wr_rdy(i_wr_rdy), .o_waddr(o_waddr), .o_wdat(o_wdat), .o_busy(o_busy),
      .o_done(o_done), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // write-ready pattern: 0 = always 1, 1 = toggle, 2 = always 0
   int wr_mode = 0;
   always @(posedge i_clk) begin
      #2;
      case (wr_mode)
         0:       i_wr_rdy = 1'b1;
         1:       i_wr_rdy = ~i_wr_rdy;
         default: i_wr_rdy = 1'b0;
      endcase
   end

   // scoreboard
   logic [CKW-1:0] exp_q[$];
   logic [AW-1:0]  exp_addr [16];
   int vectors = 0, miscompares = 0;
   int done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, start_cyc = 0, wr_seen = 0;
   bit hold_chk = 1'b0;

   task automatic check(input string nm, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // monitor
   bit             stall_prev = 1'b0;
   logic [CKW-1:0] held;
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (o_wr_en) wr_seen++;
         if (stall_prev && hold_chk)
            check("stall_hold", {o_wr_en, o_waddr, o_wdat}, held);
         if (o_wr_en && i_wr_rdy) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got addr %h with no expected write", o_waddr);
            end else begin
               check("write", {1'b0, o_waddr, o_wdat}, exp_q.pop_front());
            end
            last_wr_cyc = cyc;
         end
         stall_prev = o_wr_en && !i_wr_rdy;
         held = {1'b1, o_waddr, o_wdat};
      end
   end

   // driver tasks (all called and returning at posedge+1)
   task automatic start_job(input logic [AW-1:0] base, input int x, input int l, input int y,
                            input int run, input logic [AW-1:0] jmp);
      i_cfg_base = base;  i_cfg_x_len = CW'(x);  i_cfg_layers = CW'(l);
      i_cfg_y_len = CW'(y); i_cfg_run_len = CW'(run); i_cfg_jump = jmp;
      i_start = 1'b1;
      @(negedge i_clk);
      start_cyc = cyc;
      @(posedge i_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic send_beats(input int n, input int a0, input int tag0, input bit rnd, input bit expect_wr);
      for (int i = 0; i < n; i++) begin
         logic [31:0] tag;
         bit got;
         int budget;
         tag = 32'(tag0 + i);
         i_dat = {8{tag}};
         got = 1'b0;
         budget = 0;
         while (!got && budget < 200) begin
            i_dat_vld = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge i_clk);
            if (i_dat_vld && o_dat_rdy) begin
               got = 1'b1;
               if (expect_wr) exp_q.push_back({1'b0, exp_addr[a0 + i], i_dat});
            end
            @(posedge i_clk); #1;
            budget++;
         end
         if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: beat %0d got no ready, want accepted", i);
         end
      end
      i_dat_vld = 1'b0;
   endtask

   task automatic wait_job(input string nm);
      int n = 0;
      while ((o_busy || exp_q.size() != 0) && n < 400) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 400) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: busy=%0d pending=%0d want idle", nm, o_busy, exp_q.size());
         exp_q.delete();
      end
      @(posedge i_clk); #1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic set_linear(input logic [AW-1:0] base, input int n);
      for (int i = 0; i < n; i++) exp_addr[i] = base + AW'(i);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, w0;
      bit acc;

      // reset state
      #3;
      check("reset_ctrl", CKW'({o_dat_rdy, o_wr_en, o_busy, o_done, o_waddr}), '0);
      check("reset_wdat", CKW'(o_wdat), '0);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      idle_cycles(2);

      // T1: linear 8 beats
      hold_chk = 1'b1;
      set_linear(12'h010, 8);
      d0 = done_cnt;
      start_job(12'h010, 4, 2, 1, 0, 12'h000);
      check("t1_busy", CKW'(o_busy), CKW'(1));
      send_beats(8, 0, 32'h100, 1'b0, 1'b1);
      wait_job("t1");
      check("t1_done_count", CKW'(done_cnt - d0), CKW'(1));
      check("t1_done_latency", CKW'(done_cyc - last_wr_cyc), CKW'(1));

      // T2: run=2, jump=5
      exp_addr[0] = 12'h100; exp_addr[1] = 12'h101; exp_addr[2] = 12'h106;
      exp_addr[3] = 12'h107; exp_addr[4] = 12'h10C; exp_addr[5] = 12'h10D;
      d0 = done_cnt;
      start_job(12'h100, 3, 1, 2, 2, 12'h005);
      send_beats(6, 0, 32'h200, 1'b0, 1'b1);
      wait_job("t2");
      check("t2_done_count", CKW'(done_cnt - d0), CKW'(1));

      // T3: fill FIFO with writes blocked, then drain with toggling ready
      exp_addr[0] = 12'h020; exp_addr[1] = 12'h021; exp_addr[2] = 12'h022; exp_addr[3] = 12'h032;
      exp_addr[4] = 12'h033; exp_addr[5] = 12'h034; exp_addr[6] = 12'h044; exp_addr[7] = 12'h045;
      wr_mode = 2;
      idle_cycles(1);
      d0 = done_cnt;
      start_job(12'h020, 2, 2, 2, 3, 12'h010);
      send_beats(4, 0, 32'h300, 1'b1, 1'b1);
      @(negedge i_clk);
      check("t3_rdy_full", CKW'(o_dat_rdy), CKW'(0));
      check("t3_head", {o_wr_en, o_waddr, o_wdat}, {1'b1, 12'h020, {8{32'h300}}});
      @(posedge i_clk); #1;
      wr_mode = 1;
      send_beats(4, 4, 32'h304, 1'b1, 1'b1);
      wait_job("t3");
      check("t3_done_count", CKW'(done_cnt - d0), CKW'(1));
      wr_mode = 0;
      idle_cycles(2);

      // T4: address wrap and no acceptance past T
      exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
      d0 = done_cnt;
      start_job(12'hFFE, 4, 1, 1, 0, 12'h000);
      send_beats(4, 0, 32'h400, 1'b0, 1'b1);
      i_dat = {8{32'hDEAD0005}};
      i_dat_vld = 1'b1;
      acc = 1'b0;
      repeat (10) begin
         @(negedge i_clk);
         if (o_dat_rdy) acc = 1'b1;
      end
      @(posedge i_clk); #1;
      i_dat_vld = 1'b0;
      check("t4_beyond_total", CKW'(acc), CKW'(0));
      wait_job("t4");
      check("t4_done_count", CKW'(done_cnt - d0), CKW'(1));

      // T5a: zero-length job
      d0 = done_cnt;
      w0 = wr_seen;
      start_job(12'h050, 3, 2, 0, 0, 12'h000);
      idle_cycles(5);
      check("t5_zero_no_wr", CKW'(wr_seen - w0), CKW'(0));
      check("t5_zero_done_count", CKW'(done_cnt - d0), CKW'(1));
      check("t5_zero_done_window", CKW'((done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2)), CKW'(1));
      check("t5_zero_idle", CKW'(o_busy), CKW'(0));

      // T5b: abort after 3 of 8 writes, with 2 more beats stuck in the FIFO
      set_linear(12'h200, 3);
      d0 = done_cnt;
      start_job(12'h200, 8, 1, 1, 0, 12'h000);
      send_beats(3, 0, 32'h500, 1'b0, 1'b1);
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge i_clk);
      @(posedge i_clk); #1;
      check("t5_three_written", CKW'(exp_q.size()), CKW'(0));
      hold_chk = 1'b0;
      wr_mode = 2;
      idle_cycles(1);
      send_beats(2, 0, 32'h503, 1'b0, 1'b0);
      i_abort = 1'b1;
      @(posedge i_clk); #1;
      i_abort = 1'b0;
      @(negedge i_clk);
      check("t5_abort_state", CKW'({o_busy, o_wr_en, o_dat_rdy}), CKW'(0));
      @(posedge i_clk); #1;
      wr_mode = 0;
      idle_cycles(5);
      check("t5_abort_no_done", CKW'(done_cnt - d0), CKW'(0));

      // abort beats a same-cycle start
      i_abort = 1'b1;
      start_job(12'h0AA, 1, 1, 1, 0, 12'h000);
      i_abort = 1'b0;
      @(negedge i_clk);
      check("abort_over_start", CKW'(o_busy), CKW'(0));
      @(posedge i_clk); #1;

      // T5c: new job from new base after abort flushed the FIFO
      hold_chk = 1'b1;
      set_linear(12'h300, 2);
      d0 = done_cnt;
      start_job(12'h300, 2, 1, 1, 0, 12'h000);
      send_beats(2, 0, 32'h600, 1'b0, 1'b1);
      wait_job("t5c");
      check("t5c_done_count", CKW'(done_cnt - d0), CKW'(1));

      // T6: async reset mid-job, then a full rerun
      set_linear(12'h010, 8);
      start_job(12'h010, 4, 2, 1, 0, 12'h000);
      send_beats(3, 0, 32'h700, 1'b0, 1'b1);
      @(negedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("t6_rst_ctrl", CKW'({o_dat_rdy, o_wr_en, o_busy, o_done, o_waddr}), '0);
      check("t6_rst_wdat", CKW'(o_wdat), '0);
      exp_q.delete();
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      idle_cycles(1);
      d0 = done_cnt;
      start_job(12'h010, 4, 2, 1, 0, 12'h000);
      send_beats(8, 0, 32'h800, 1'b0, 1'b1);
      wait_job("t6");
      check("t6_done_count", CKW'(done_cnt - d0), CKW'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
